rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the register file. It shares the file's single write port between two requesters: A is ALU write-back and B is load/move write-back. Each requester has a valid/ready handshake and a one-entry holding slot. The block drives one-hot per-register `regWrite` strobes and a common write-data bus into the `rf_reg` instances, with round-robin priority under contention.

## Interface
- `BUS_WIDTH`, 16, data width of every register and of the write bus
- `NUM_REGS`, 8, number of registers in the file
- `ADDR_WIDTH`, $clog2(NUM_REGS), register address width
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `a_valid`  input  1  requester A presents a write
- `a_ready`  output  1  A slot can accept this cycle
- `a_addr`  input  ADDR_WIDTH  A destination register
- `a_data`  input  BUS_WIDTH  A write data
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as A, for requester B
- `reg_write`  output  NUM_REGS  one-hot write strobes, bit i to register i `regWrite`
- `wr_data`  output  BUS_WIDTH  common write bus to every register `in`
- `last_grant`  output  1  0 = A, 1 = B; requester granted most recently

## Operation
- Each requester owns a slot holding `full`, `addr` and `data`.
- Handshake:
  - Transfer occurs when valid && ready at a rising edge; the slot captures `addr`/`data` and sets `full`.
  - `x_ready = !x_full || x_grant`. It depends only on registered state, never on `x_valid`.
  - Data must be held stable only in the transfer cycle.
- Grant logic is combinational on the slot states:
  - Only one slot full: that slot wins.
  - Both full: the slot that is not `last_grant` wins.
  - Neither full: no grant.
- On a granted edge:
  - `reg_write` <= one-hot(winner addr).
  - `wr_data` <= winner data.
  - `last_grant` <= winner.
  - Winner's slot clears `full`, unless a new transfer refills it on the same edge.
- On an edge with no grant, `reg_write` <= 0 and `wr_data` holds its value.
- Address `>= NUM_REGS` (non-power-of-two file): the grant and handshake complete normally, but `reg_write` is all zero. The write is silently dropped.
- Both slots targeting the same address: the writes are serialized in grant order, so the later grant's data ends up in the register.
- At most one bit of `reg_write` is ever set.

## Timing
- Reset values:
  - `reg_write` = 0
  - `wr_data` = 0
  - `last_grant` = 1, so A wins the first contention
  - both slots empty, so `a_ready` = `b_ready` = 1 in the cycle after reset
- Reset mid-operation: all pending slot contents are discarded with no write issued. A `reg_write` pulse already asserted is deasserted at the reset edge.
- Latency, uncontested:
  - Transfer at edge E0.
  - Grant at E1; `reg_write` is high for the cycle after E1.
  - The `rf_reg` latches the data at E2.
- Latency, contested: the loser is granted one edge later than the winner. Worst-case transfer-to-strobe is 2 edges.
- Throughput: one write per cycle overall. A single uncontested requester may transfer every cycle. Under continuous contention each requester gets every other cycle.
- `reg_write` is a single-cycle pulse per grant; consecutive grants give back-to-back pulses.

## Configuration
- `RF_WB_ZERO_REG_EN`
  - Defined: register 0 is hardwired zero. A grant with addr 0 completes the handshake and updates `last_grant`, but forces `reg_write` = 0, so register 0 keeps its value.
  - Undefined: register 0 is an ordinary writable register.

## Structure
- Package `rf_pkg` holds:
  - default `BUS_WIDTH` and `NUM_REGS` constants
  - requester index typedef (`REQ_A` = 0, `REQ_B` = 1)
  - the one-hot decode function
- Sub-module `rf_wb_slot` is the one-entry holding register (full/addr/data, capture and clear). It is instantiated twice.

## Test plan
- Reset, then A writes addr 3 / 0x1234 for one cycle -> `reg_write` = 8'b0000_1000 and `wr_data` = 0x1234 for exactly one cycle, one edge after the transfer; `last_grant` = 0.
- A (addr 1, 0xAAAA) and B (addr 2, 0xBBBB) transfer on the same edge right after reset -> A strobe first, B strobe next cycle; `last_grant` ends at 1.
- Both requesters hold valid for 6 cycles -> strobes alternate A, B, A, B…; each `x_ready` is high every other cycle; no cycle has two `reg_write` bits set.
- A and B both target addr 5, with 0x0001 from A granted first -> final register 5 value is 0x0002 (B's data).
- Assert `rst` with both slots full and a pulse in flight -> `reg_write` is 0 and `wr_data` is 0 after the edge; no later strobe occurs for the discarded requests.
- Write to addr 0 with `RF_WB_ZERO_REG_EN` defined -> handshake completes and `reg_write` stays 0. With the macro undefined -> `reg_write` = 8'b0000_0001.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and helpers for the register-file write-back arbiter.
// Package rf_pkg: default sizes, requester index and one-hot decode.
package rf_pkg;

    localparam int DEF_BUS_WIDTH = 16;
    localparam int DEF_NUM_REGS  = 8;
    localparam int MAX_REGS      = 64;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_t;

    // Out-of-range addresses decode to all-zero so the write is dropped.
    function automatic logic [MAX_REGS-1:0] onehot_decode(
        input logic [31:0] addr,
        input logic [31:0] num_regs
    );
        logic [MAX_REGS-1:0] one;
        one = MAX_REGS'(1);
        return (addr < num_regs) ? (one << addr) : '0;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Requester handshakes plus register-file write port of rf_wb_arbiter.
interface rf_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int NUM_REGS  = DEF_NUM_REGS
);
    localparam int ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                  a_valid;
    logic                  a_ready;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [BUS_WIDTH-1:0]  a_data;

    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [BUS_WIDTH-1:0]  b_data;

    logic [NUM_REGS-1:0]   reg_write;
    logic [BUS_WIDTH-1:0]  wr_data;
    logic                  last_grant;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, reg_write, wr_data, last_grant
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, reg_write, wr_data, last_grant
    );

endinterface

// File: rtl/rf_wb_arbiter_slot.sv
// rf_wb_slot: one-entry holding register (full/addr/data) for a requester.
module rf_wb_slot
    import rf_pkg::*;
#(
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [BUS_WIDTH-1:0]  i_data,
    input  logic                  i_grant,
    output logic                  o_ready,
    output logic                  o_full,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [BUS_WIDTH-1:0]  o_data
);

    logic                  r_full;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BUS_WIDTH-1:0]  r_data;
    logic                  w_xfer;

    // A slot being drained this edge can be refilled on the same edge.
    assign o_ready = !r_full || i_grant;
    assign w_xfer  = i_valid && o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
        end else if (w_xfer) begin
            r_full <= 1'b1;
        end else if (i_grant) begin
            r_full <= 1'b0;
        end
    end

    // NOTE: payload has no reset; it is only observed while r_full is set.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_addr <= i_addr;
            r_data <= i_data;
        end
    end

    assign o_full = r_full;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register-file write port.
// Optional RF_WB_ZERO_REG_EN: register 0 is hardwired zero (writes dropped).
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input logic             clk,
    input logic             rst,
    rf_wb_arbiter_if.slave  bus
);

    logic                  w_a_full, w_b_full;
    logic [ADDR_WIDTH-1:0] w_a_addr, w_b_addr;
    logic [BUS_WIDTH-1:0]  w_a_data, w_b_data;
    logic                  w_a_grant, w_b_grant;
    logic                  w_any;
    req_t                  w_winner;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [BUS_WIDTH-1:0]  w_win_data;
    logic [NUM_REGS-1:0]   w_strobe;

    logic [NUM_REGS-1:0]   r_reg_write;
    logic [BUS_WIDTH-1:0]  r_wr_data;
    req_t                  r_last_grant;

    rf_wb_slot #(.BUS_WIDTH(BUS_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_slot_a (
        .clk(clk), .rst(rst),
        .i_valid(bus.a_valid), .i_addr(bus.a_addr), .i_data(bus.a_data),
        .i_grant(w_a_grant), .o_ready(bus.a_ready),
        .o_full(w_a_full), .o_addr(w_a_addr), .o_data(w_a_data)
    );

    rf_wb_slot #(.BUS_WIDTH(BUS_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_slot_b (
        .clk(clk), .rst(rst),
        .i_valid(bus.b_valid), .i_addr(bus.b_addr), .i_data(bus.b_data),
        .i_grant(w_b_grant), .o_ready(bus.b_ready),
        .o_full(w_b_full), .o_addr(w_b_addr), .o_data(w_b_data)
    );

    // Under contention the requester not granted last time wins.
    always_comb begin
        w_winner = REQ_A;
        if (w_a_full && w_b_full) begin
            w_winner = (r_last_grant == REQ_A) ? REQ_B : REQ_A;
        end else if (w_b_full) begin
            w_winner = REQ_B;
        end
    end

    assign w_any      = w_a_full || w_b_full;
    assign w_a_grant  = w_any && (w_winner == REQ_A);
    assign w_b_grant  = w_any && (w_winner == REQ_B);
    assign w_win_addr = (w_winner == REQ_B) ? w_b_addr : w_a_addr;
    assign w_win_data = (w_winner == REQ_B) ? w_b_data : w_a_data;

    always_comb begin
        w_strobe = NUM_REGS'(onehot_decode(32'(w_win_addr), 32'(NUM_REGS)));
`ifdef RF_WB_ZERO_REG_EN
        if (w_win_addr == '0) begin
            w_strobe = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write  <= '0;
            r_wr_data    <= '0;
            r_last_grant <= REQ_B;
        end else if (w_any) begin
            r_reg_write  <= w_strobe;
            r_wr_data    <= w_win_data;
            r_last_grant <= w_winner;
        end else begin
            r_reg_write  <= '0;
        end
    end

    assign bus.reg_write  = r_reg_write;
    assign bus.wr_data    = r_wr_data;
    assign bus.last_grant = r_last_grant;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scenarios for rf_wb_arbiter with an in-order write scoreboard.
module tb_rf_wb_arbiter;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    logic [15:0] regs [8];

    rf_wb_arbiter_if #(.BUS_WIDTH(16), .NUM_REGS(8)) bus ();

    rf_wb_arbiter #(.BUS_WIDTH(16), .NUM_REGS(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Advance one edge, then score any strobe against the expected queue.
    task automatic cycle();
        exp_t       e;
        logic [7:0] exp_rw;
        @(posedge clk);
        #1;
        n_checks++;
        if ($countones(bus.reg_write) > 1) begin
            n_fail++;
            $display("FAIL onehot: got reg_write=%b, want at most one bit set", bus.reg_write);
        end
        if (bus.reg_write !== 8'h00) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got reg_write=%b wr_data=%h, want no strobe",
                         bus.reg_write, bus.wr_data);
            end else begin
                e = q.pop_front();
                exp_rw = 8'b1 << e.addr;
                if (bus.reg_write !== exp_rw || bus.wr_data !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_write: got reg_write=%b wr_data=%h, want reg_write=%b wr_data=%h",
                             bus.reg_write, bus.wr_data, exp_rw, e.data);
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (bus.reg_write[i]) regs[i] = bus.wr_data;
            end
        end
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cycle();
        cycle();
        q.delete();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.reg_write !== 8'h00) begin
            n_fail++; $display("FAIL reset_reg_write: got %b, want 00000000", bus.reg_write);
        end
        n_checks++;
        if (bus.wr_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_wr_data: got %h, want 0000", bus.wr_data);
        end
        n_checks++;
        if (bus.last_grant !== 1'b1) begin
            n_fail++; $display("FAIL reset_last_grant: got %b, want 1", bus.last_grant);
        end
        n_checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got a=%b b=%b, want a=1 b=1", bus.a_ready, bus.b_ready);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        bus.a_valid = 1'b1; bus.a_addr = 3'd3; bus.a_data = 16'h1234;
        q.push_back('{addr: 3'd3, data: 16'h1234});
        cycle();
        bus.a_valid = 1'b0; bus.a_data = 16'hDEAD;
        n_checks++;
        if (bus.reg_write !== 8'h00) begin
            n_fail++; $display("FAIL single_early: got %b, want 00000000", bus.reg_write);
        end
        cycle();
        n_checks++;
        if (bus.reg_write !== 8'b0000_1000 || bus.wr_data !== 16'h1234) begin
            n_fail++; $display("FAIL single_strobe: got %b/%h, want 00001000/1234", bus.reg_write, bus.wr_data);
        end
        n_checks++;
        if (bus.last_grant !== 1'b0) begin
            n_fail++; $display("FAIL single_last_grant: got %b, want 0", bus.last_grant);
        end
        cycle();
        n_checks++;
        if (bus.reg_write !== 8'h00) begin
            n_fail++; $display("FAIL single_pulse_width: got %b, want 00000000", bus.reg_write);
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL single_missing: got %0d pending, want 0", q.size());
        end
    endtask

    task automatic test_two_requesters();
        do_reset();
        bus.a_valid = 1'b1; bus.a_addr = 3'd1; bus.a_data = 16'hAAAA;
        bus.b_valid = 1'b1; bus.b_addr = 3'd2; bus.b_data = 16'hBBBB;
        q.push_back('{addr: 3'd1, data: 16'hAAAA});
        q.push_back('{addr: 3'd2, data: 16'hBBBB});
        cycle();
        idle_inputs();
        cycle();
        n_checks++;
        if (bus.reg_write !== 8'b0000_0010) begin
            n_fail++; $display("FAIL two_first: got %b, want 00000010", bus.reg_write);
        end
        cycle();
        n_checks++;
        if (bus.reg_write !== 8'b0000_0100) begin
            n_fail++; $display("FAIL two_second: got %b, want 00000100", bus.reg_write);
        end
        n_checks++;
        if (bus.last_grant !== 1'b1) begin
            n_fail++; $display("FAIL two_last_grant: got %b, want 1", bus.last_grant);
        end
        cycle();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL two_missing: got %0d pending, want 0", q.size());
        end
    endtask

    task automatic test_contention();
        int   ka = 0;
        int   kb = 0;
        logic a_x, b_x;
        do_reset();
        bus.a_valid = 1'b1; bus.a_addr = 3'd6;
        bus.b_valid = 1'b1; bus.b_addr = 3'd7;
        for (int e = 0; e < 6; e++) begin
            bus.a_data = 16'hA000 + 16'(ka);
            bus.b_data = 16'hB000 + 16'(kb);
            a_x = bus.a_ready;
            b_x = bus.b_ready;
            if (a_x) q.push_back('{addr: 3'd6, data: bus.a_data});
            if (b_x) q.push_back('{addr: 3'd7, data: bus.b_data});
            cycle();
            if (a_x) ka++;
            if (b_x) kb++;
            n_checks++;
            if (bus.a_ready !== (e % 2 == 0) || bus.b_ready !== (e % 2 == 1)) begin
                n_fail++;
                $display("FAIL contention_ready[%0d]: got a=%b b=%b, want a=%b b=%b",
                         e, bus.a_ready, bus.b_ready, (e % 2 == 0), (e % 2 == 1));
            end
        end
        idle_inputs();
        repeat (4) cycle();
        n_checks++;
        if (ka != 4 || kb != 3) begin
            n_fail++; $display("FAIL contention_xfers: got a=%0d b=%0d, want a=4 b=3", ka, kb);
        end
        n_checks++;
        if (bus.last_grant !== 1'b0) begin
            n_fail++; $display("FAIL contention_last_grant: got %b, want 0", bus.last_grant);
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL contention_missing: got %0d pending, want 0", q.size());
        end
    endtask

    task automatic test_same_addr();
        do_reset();
        bus.a_valid = 1'b1; bus.a_addr = 3'd5; bus.a_data = 16'h0001;
        bus.b_valid = 1'b1; bus.b_addr = 3'd5; bus.b_data = 16'h0002;
        q.push_back('{addr: 3'd5, data: 16'h0001});
        q.push_back('{addr: 3'd5, data: 16'h0002});
        cycle();
        idle_inputs();
        repeat (3) cycle();
        n_checks++;
        if (regs[5] !== 16'h0002) begin
            n_fail++; $display("FAIL same_addr_final: got %h, want 0002", regs[5]);
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL same_addr_missing: got %0d pending, want 0", q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int e = 0; e < 4; e++) begin
            n_checks++;
            if (bus.a_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_ready[%0d]: got %b, want 1", e, bus.a_ready);
            end
            bus.a_valid = 1'b1; bus.a_addr = 3'(e + 1); bus.a_data = 16'hC000 + 16'(e);
            q.push_back('{addr: 3'(e + 1), data: 16'hC000 + 16'(e)});
            cycle();
            if (e > 0) begin
                n_checks++;
                if (bus.reg_write === 8'h00) begin
                    n_fail++; $display("FAIL b2b_gap[%0d]: got 00000000, want a strobe", e);
                end
            end
        end
        idle_inputs();
        repeat (2) cycle();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL b2b_missing: got %0d pending, want 0", q.size());
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        bus.a_valid = 1'b1; bus.a_addr = 3'd1; bus.a_data = 16'h1111;
        bus.b_valid = 1'b1; bus.b_addr = 3'd2; bus.b_data = 16'h2222;
        q.push_back('{addr: 3'd1, data: 16'h1111});
        cycle();
        bus.a_data = 16'h3333;
        bus.b_valid = 1'b0;
        cycle();
        n_checks++;
        if (bus.reg_write !== 8'b0000_0010) begin
            n_fail++; $display("FAIL midrst_inflight: got %b, want 00000010", bus.reg_write);
        end
        idle_inputs();
        rst = 1'b1;
        cycle();
        n_checks++;
        if (bus.reg_write !== 8'h00 || bus.wr_data !== 16'h0000) begin
            n_fail++; $display("FAIL midrst_clear: got %b/%h, want 00000000/0000", bus.reg_write, bus.wr_data);
        end
        rst = 1'b0;
        repeat (4) cycle();
        n_checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1 || bus.last_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_state: got a=%b b=%b lg=%b, want a=1 b=1 lg=1",
                     bus.a_ready, bus.b_ready, bus.last_grant);
        end
    endtask

    task automatic test_zero_reg();
        logic [7:0] exp_rw;
        do_reset();
`ifdef RF_WB_ZERO_REG_EN
        exp_rw = 8'h00;
`else
        exp_rw = 8'b0000_0001;
        q.push_back('{addr: 3'd0, data: 16'h5A5A});
`endif
        bus.a_valid = 1'b1; bus.a_addr = 3'd0; bus.a_data = 16'h5A5A;
        cycle();
        idle_inputs();
        cycle();
        n_checks++;
        if (bus.reg_write !== exp_rw) begin
            n_fail++; $display("FAIL zero_reg_strobe: got %b, want %b", bus.reg_write, exp_rw);
        end
        n_checks++;
        if (bus.last_grant !== 1'b0) begin
            n_fail++; $display("FAIL zero_reg_last_grant: got %b, want 0", bus.last_grant);
        end
        cycle();
        n_checks++;
        if (bus.a_ready !== 1'b1 || q.size() != 0) begin
            n_fail++; $display("FAIL zero_reg_done: got ready=%b pending=%0d, want ready=1 pending=0",
                               bus.a_ready, q.size());
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_two_requesters();
        test_contention();
        test_same_addr();
        test_back_to_back();
        test_reset_mid_op();
        test_zero_reg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
